// File: rtl/acs_state_node_if.sv
// Symbol-step bus of one ACS trellis node: predecessor metrics and branch metrics come in,
// and the node's path metric, survivor decision and frame status go out.
interface acs_state_node_if #(
  parameter int PM_W = 8,
  parameter int BM_W = 2
);
  logic            start;
  logic            in_valid;
  logic [PM_W-1:0] pm_a;
  logic [PM_W-1:0] pm_b;
  logic [BM_W-1:0] bm_a;
  logic [BM_W-1:0] bm_b;
  logic            norm_in;
  logic [PM_W-1:0] pm_out;
  logic            pm_msb;
  logic            dec_out;
  logic            out_valid;
  logic            frame_done;

  modport master (
    output start, in_valid, pm_a, pm_b, bm_a, bm_b, norm_in,
    input  pm_out, pm_msb, dec_out, out_valid, frame_done
  );

  modport slave (
    input  start, in_valid, pm_a, pm_b, bm_a, bm_b, norm_in,
    output pm_out, pm_msb, dec_out, out_valid, frame_done
  );
endinterface

// File: rtl/acs_state_node.sv
// Add-compare-select node for one Viterbi trellis state: keeps the state's path metric,
// applies global normalization and saturation, and counts symbols per frame.
module acs_state_node #(
  parameter int PM_W      = 8,
  parameter int BM_W      = 2,
  parameter int INIT_ZERO = 0,
  parameter int FRAME_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  acs_state_node_if.slave   bus
);
  localparam int              CNT_W    = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [PM_W-1:0] INIT_PM  = (INIT_ZERO != 0) ? '0 : {2'b01, {(PM_W-2){1'b0}}};
  localparam logic [PM_W:0]   NORM_SUB = {2'b01, {(PM_W-1){1'b0}}};
  localparam logic [PM_W:0]   PM_MAX   = {1'b0, {PM_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             load, step, last_step;
  logic [PM_W:0]    sum_a, sum_b, sel_raw, sel_norm;
  logic             dec;
  logic [PM_W-1:0]  pm_next;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    if (bus.start) begin
      // A new frame wins over any in-flight symbol, which is dropped.
      load       = 1'b1;
      state_next = RUN;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        RUN: begin
          if (bus.in_valid) begin
            step = 1'b1;
            if (cnt == LAST_CNT) state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign last_step = step && (cnt == LAST_CNT);

  // Sums carry one extra bit so saturation can see the overflow.
  assign sum_a    = {1'b0, bus.pm_a} + {{(PM_W+1-BM_W){1'b0}}, bus.bm_a};
  assign sum_b    = {1'b0, bus.pm_b} + {{(PM_W+1-BM_W){1'b0}}, bus.bm_b};
  assign dec      = (sum_b < sum_a);
  assign sel_raw  = dec ? sum_b : sum_a;
  assign sel_norm = bus.norm_in ? (sel_raw - NORM_SUB) : sel_raw;
  assign pm_next  = (sel_norm > PM_MAX) ? {PM_W{1'b1}} : sel_norm[PM_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pm_out     <= '0;
      bus.dec_out    <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      cnt            <= '0;
    end else begin
      bus.out_valid  <= step;
      bus.frame_done <= last_step;
      if (load) begin
        bus.pm_out <= INIT_PM;
        cnt        <= '0;
      end else if (step) begin
        bus.pm_out  <= pm_next;
        bus.dec_out <= dec;
        cnt         <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pm_msb = bus.pm_out[PM_W-1];
endmodule
